can_tx_scheduler: RTL and testbench
===================================

# can_tx_scheduler

- Transmit-side scheduler for the CAN node.
- Arbitrates among NUM_MB transmit mailboxes by CAN priority: the lowest identifier wins, and on equal IDs the lowest index wins.
- Waits for bus idle, which it measures on the same serial line the receiver samples.
- Drives the bit-level transmitter with a start/done/lost handshake, and retries lost arbitration up to a limit.

## Interface

Parameters:
- NUM_MB, 4: number of mailboxes, 2..8.
- ID_W, 11: identifier width; 11 for standard frames, 29 for extended.
- CLKS_PER_BIT, 10: clocks per CAN bit, same meaning as in the receiver.
- IDLE_BITS, 11: consecutive recessive bits that declare the bus idle.
- MAX_RETRY, 15: lost attempts tolerated before a mailbox is aborted, 1..255.
- TIMEOUT_BITS, 160: watchdog length in bits; used only with CAN_SCHED_TIMEOUT_EN.

Ports:
- i_Clock  in  1  system clock; all logic on rising edge.
- i_Reset_n  in  1  asynchronous, active-low reset.
- i_Rx_Serial  in  1  CAN bus level; 1 is recessive.
- i_Req  in  NUM_MB  per-mailbox request level; held until o_Ack or o_Abort.
- i_Id  in  NUM_MB*ID_W  packed IDs; mailbox k is at [k*ID_W +: ID_W].
- o_Grant  out  NUM_MB  one-hot grant; held from SELECT through completion.
- o_Tx_Start  out  1  one-cycle pulse telling the transmitter to send.
- o_Tx_Id  out  ID_W  ID of the granted mailbox; stable while o_Busy=1.
- i_Tx_Done  in  1  one-cycle pulse: frame sent and acknowledged.
- i_Tx_Lost  in  1  one-cycle pulse: arbitration lost or error.
- o_Ack  out  NUM_MB  one-cycle pulse to the completed mailbox.
- o_Abort  out  NUM_MB  one-cycle pulse: mailbox exhausted its retries.
- o_Busy  out  1  high in states START and ACTIVE.

## Operation

**Bus-idle detector**
- i_Rx_Serial passes through a 2-flop synchronizer; both flops reset to 1.
- A counter increments on each clock the synchronized bit is 1 and saturates at IDLE_BITS*CLKS_PER_BIT.
- Any 0 clears the counter.
- bus_idle = (counter == IDLE_BITS*CLKS_PER_BIT). It is 0 after reset, so the bus must prove itself idle.

**Eligibility**
- eligible[k] = i_Req[k] & ~blocked[k].
- blocked[k] is set on o_Abort[k] and cleared on any clock where i_Req[k]=0.

**FSM**
- IDLE: go to WAIT_BUS when any eligible bit is set.
- WAIT_BUS: go to SELECT when bus_idle=1. Go to IDLE if no eligible bit remains.
- SELECT (1 cycle):
  - Register the winner into o_Grant and o_Tx_Id.
  - Winner is the minimum i_Id over eligible mailboxes; ties go to the lowest index.
  - Go to IDLE if none is eligible.
  - Load the retry counter with 0 only if the winner differs from the previous grant.
- START (1 cycle): o_Tx_Start=1, then go to ACTIVE.
- ACTIVE: wait for a handshake pulse.
  - i_Tx_Done: pulse o_Ack[winner], clear o_Grant, go to IDLE.
  - i_Tx_Lost: increment the retry counter.
    - If the count reaches MAX_RETRY: pulse o_Abort[winner], set blocked, clear the retry counter, go to IDLE.
    - Otherwise go to WAIT_BUS and re-arbitrate, so a higher-priority arrival can preempt.

**Boundary rules**
- i_Tx_Done and i_Tx_Lost in the same cycle: Done wins.
- Handshake pulses outside ACTIVE are ignored.
- i_Req/i_Id changes during START/ACTIVE are ignored; the grant is frozen.
- A winner's request dropping while in WAIT_BUS is honoured at the next SELECT.
- Retry counter is 8 bits and saturating.

## Timing

- Reset values (asynchronous): state IDLE; o_Grant, o_Tx_Start, o_Tx_Id, o_Ack, o_Abort, o_Busy all 0; blocked 0; retry 0; idle counter 0.
- A reset mid-transaction drops the grant with no o_Ack or o_Abort pulse.
- All outputs are registered.
- With bus_idle already 1 and i_Req[k] first sampled high at edge t:
  - state is WAIT_BUS after t+1;
  - SELECT after t+2, with o_Grant and o_Tx_Id valid from t+2;
  - o_Tx_Start high for the single cycle after edge t+3.
- o_Ack/o_Abort are high for the cycle after the edge sampling i_Tx_Done/i_Tx_Lost. o_Grant clears on that same edge.
- Minimum request-to-request turnaround after o_Ack is 3 clocks, plus any bus-idle wait.

## Configuration

- CAN_SCHED_TIMEOUT_EN defined:
  - A watchdog counts clocks in ACTIVE.
  - Reaching TIMEOUT_BITS*CLKS_PER_BIT without Done or Lost is treated exactly as i_Tx_Lost, including the retry count.
  - The watchdog clears on entry to ACTIVE.
- Not defined: no watchdog logic; ACTIVE waits indefinitely.

## Test plan

- Reset release, bus held 1 for 110 clocks (IDLE_BITS=11, CLKS_PER_BIT=10), then i_Req=4'b0001, ID0=0x123 -> o_Tx_Start pulses 3 clocks later; o_Tx_Id=0x123; o_Grant=0001. Then i_Tx_Done -> o_Ack=0001 for 1 cycle.
- i_Req=4'b1110 with IDs 0x400/0x0FF/0x0FF -> grant 0010 (tie on 0x0FF, lowest index). After Done and that request dropping -> next grant 0100, then 1000.
- Bus driven 0 at clock 105 of the idle window -> no o_Tx_Start until 110 further consecutive recessive clocks.
- MAX_RETRY=3; i_Tx_Lost after each start -> three starts, then o_Abort=0001. No further grant to mailbox 0 until i_Req[0] deasserts and reasserts.
- Lost on mailbox 2 (ID 0x200) while mailbox 0 (ID 0x010) raises its request -> re-arbitration grants 0001; simultaneous Done+Lost -> o_Ack only.
- With CAN_SCHED_TIMEOUT_EN and TIMEOUT_BITS=4: no handshake for 40 clocks in ACTIVE -> retry counter increments and FSM returns to WAIT_BUS. Without the macro -> o_Busy stays 1.

Source files
------------

// File: rtl/can_tx_scheduler.sv
// CAN transmit scheduler: lowest-ID mailbox arbitration, bus-idle wait, retry/abort (watchdog under CAN_SCHED_TIMEOUT_EN).
// Latency: request sampled at edge t -> grant after t+2, o_Tx_Start pulse after t+3; all outputs registered.
// Backpressure: requests wait until the bus is idle; a grant stays frozen from SELECT until Done, abort or reset.
module can_tx_scheduler #(
   parameter int NUM_MB       = 4,
   parameter int ID_W         = 11,
   parameter int CLKS_PER_BIT = 10,
   parameter int IDLE_BITS    = 11,
   parameter int MAX_RETRY    = 15,
   parameter int TIMEOUT_BITS = 160
) (
   input  logic                   i_Clock,
   input  logic                   i_Reset_n,
   input  logic                   i_Rx_Serial,
   input  logic [NUM_MB-1:0]      i_Req,
   input  logic [NUM_MB*ID_W-1:0] i_Id,
   output logic [NUM_MB-1:0]      o_Grant,
   output logic                   o_Tx_Start,
   output logic [ID_W-1:0]        o_Tx_Id,
   input  logic                   i_Tx_Done,
   input  logic                   i_Tx_Lost,
   output logic [NUM_MB-1:0]      o_Ack,
   output logic [NUM_MB-1:0]      o_Abort,
   output logic                   o_Busy
);

   typedef enum logic [2:0] {S_IDLE, S_WAIT_BUS, S_SELECT, S_START, S_ACTIVE} state_t;

   localparam int IDLE_MAX = IDLE_BITS * CLKS_PER_BIT;
   localparam int IC_W     = $clog2(IDLE_MAX + 1);

   state_t                   state, next_state;
   logic                     rx_meta, rx_sync;
   logic [IC_W-1:0]          idle_cnt;
   logic                     bus_idle;
   logic [NUM_MB-1:0]        req_q, blocked, eligible;
   logic [NUM_MB*ID_W-1:0]   id_q;
   logic [NUM_MB-1:0]        win_oh;
   logic [ID_W-1:0]          win_id;
   logic                     win_found;
   logic [7:0]               retry, retry_inc, retry_d;
   logic                     retry_limit, done_ev, lost_ev, wd_expired;
   logic [NUM_MB-1:0]        grant_d, ack_d, abort_d, blocked_d;
   logic [ID_W-1:0]          tx_id_d;

   // Idle is measured on the synchronized receive line; reset forces a full idle window.
   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         rx_meta  <= 1'b1;
         rx_sync  <= 1'b1;
         idle_cnt <= '0;
      end else begin
         rx_meta <= i_Rx_Serial;
         rx_sync <= rx_meta;
         if (!rx_sync)
            idle_cnt <= '0;
         else if (!bus_idle)
            idle_cnt <= idle_cnt + IC_W'(1);
      end
   end
   assign bus_idle = (idle_cnt == IC_W'(IDLE_MAX));

   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         req_q <= '0;
         id_q  <= '0;
      end else begin
         req_q <= i_Req;
         id_q  <= i_Id;
      end
   end

   assign eligible = req_q & ~blocked;

   // Strict less-than keeps the lowest index on equal identifiers.
   always_comb begin
      win_oh    = '0;
      win_id    = '0;
      win_found = 1'b0;
      for (int k = 0; k < NUM_MB; k++) begin
         if (eligible[k] && (!win_found || id_q[k*ID_W +: ID_W] < win_id)) begin
            win_found = 1'b1;
            win_id    = id_q[k*ID_W +: ID_W];
            win_oh    = NUM_MB'(1) << k;
         end
      end
   end

`ifdef CAN_SCHED_TIMEOUT_EN
   localparam int WD_MAX = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int WD_W   = $clog2(WD_MAX + 1);
   logic [WD_W-1:0] wd_cnt;

   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n)
         wd_cnt <= '0;
      else if (state != S_ACTIVE)
         wd_cnt <= '0;
      else
         wd_cnt <= wd_cnt + WD_W'(1);
   end
   assign wd_expired = (state == S_ACTIVE) && (wd_cnt == WD_W'(WD_MAX - 1));
`else
   assign wd_expired = 1'b0;
`endif

   assign done_ev     = (state == S_ACTIVE) && i_Tx_Done;
   assign lost_ev     = (state == S_ACTIVE) && !i_Tx_Done && (i_Tx_Lost || wd_expired);
   assign retry_inc   = (retry == 8'hFF) ? retry : retry + 8'd1;
   assign retry_limit = (retry_inc >= 8'(MAX_RETRY));

   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n)
         state <= S_IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:     if (|eligible) next_state = S_WAIT_BUS;
         S_WAIT_BUS: begin
            if (!(|eligible))
               next_state = S_IDLE;
            else if (bus_idle)
               next_state = S_SELECT;
         end
         S_SELECT:   next_state = (|(o_Grant & eligible)) ? S_START : S_IDLE;
         S_START:    next_state = S_ACTIVE;
         S_ACTIVE: begin
            if (done_ev)
               next_state = S_IDLE;
            else if (lost_ev)
               next_state = retry_limit ? S_IDLE : S_WAIT_BUS;
         end
         default:    next_state = S_IDLE;
      endcase
   end

   always_comb begin
      grant_d   = o_Grant;
      tx_id_d   = o_Tx_Id;
      ack_d     = '0;
      abort_d   = '0;
      retry_d   = retry;
      blocked_d = blocked & i_Req;
      if (state == S_WAIT_BUS && next_state == S_SELECT) begin
         grant_d = win_oh;
         tx_id_d = win_id;
         if (win_oh != o_Grant)
            retry_d = '0;
      end
      if (done_ev)
         ack_d = o_Grant;
      if (lost_ev) begin
         if (retry_limit) begin
            abort_d   = o_Grant;
            blocked_d = blocked_d | o_Grant;
            retry_d   = '0;
         end else begin
            retry_d = retry_inc;
         end
      end
      if (next_state == S_IDLE)
         grant_d = '0;
   end

   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         o_Grant    <= '0;
         o_Tx_Id    <= '0;
         o_Tx_Start <= 1'b0;
         o_Busy     <= 1'b0;
         o_Ack      <= '0;
         o_Abort    <= '0;
         retry      <= '0;
         blocked    <= '0;
      end else begin
         o_Grant    <= grant_d;
         o_Tx_Id    <= tx_id_d;
         o_Tx_Start <= (next_state == S_START);
         o_Busy     <= (next_state == S_START) || (next_state == S_ACTIVE);
         o_Ack      <= ack_d;
         o_Abort    <= abort_d;
         retry      <= retry_d;
         blocked    <= blocked_d;
      end
   end

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Directed bench for can_tx_scheduler: arbitration, idle detection, retry/abort, preemption and reset.
module tb_can_tx_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rx;
   logic [3:0]  req;
   logic [43:0] ids;
   logic [3:0]  grant;
   logic        tx_start;
   logic [10:0] tx_id;
   logic        done, lost;
   logic [3:0]  ack, abort_p;
   logic        busy;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   can_tx_scheduler #(
      .NUM_MB(4), .ID_W(11), .CLKS_PER_BIT(10), .IDLE_BITS(11),
      .MAX_RETRY(3), .TIMEOUT_BITS(4)
   ) dut (
      .i_Clock(clk), .i_Reset_n(rst_n), .i_Rx_Serial(rx),
      .i_Req(req), .i_Id(ids),
      .o_Grant(grant), .o_Tx_Start(tx_start), .o_Tx_Id(tx_id),
      .i_Tx_Done(done), .i_Tx_Lost(lost),
      .o_Ack(ack), .o_Abort(abort_p), .o_Busy(busy)
   );

   always #5 clk = ~clk;

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Returns clocks until o_Tx_Start is seen, or -1 if it never comes.
   task automatic wait_start(output int n);
      n = 0;
      forever begin
         wait_clk(1);
         n++;
         if (tx_start) break;
         if (n >= 400) begin n = -1; break; end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; rx = 1'b1; req = '0; ids = '0; done = 1'b0; lost = 1'b0;
      #12;
      chk_cnt++; if ({grant, tx_start, tx_id, busy} !== 17'd0) $display("FAIL reset_outs: got %h expected 0", {grant, tx_start, tx_id, busy}); else pass_cnt++;
      chk_cnt++; if ({ack, abort_p} !== 8'd0) $display("FAIL reset_pulses: got %h expected 0", {ack, abort_p}); else pass_cnt++;
      #10 rst_n = 1'b1;
      wait_clk(115);
      chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b expected 0", busy); else pass_cnt++;
   endtask

   task automatic test_basic();
      ids = {11'h0, 11'h0, 11'h0, 11'h123};
      req = 4'b0001;
      wait_clk(1);
      chk_cnt++; if (grant !== 4'b0000) $display("FAIL basic_early_grant: got %b expected 0000", grant); else pass_cnt++;
      wait_clk(2);
      chk_cnt++; if (grant !== 4'b0001) $display("FAIL basic_grant: got %b expected 0001", grant); else pass_cnt++;
      chk_cnt++; if (tx_id !== 11'h123) $display("FAIL basic_tx_id: got %h expected 123", tx_id); else pass_cnt++;
      chk_cnt++; if (tx_start !== 1'b0) $display("FAIL basic_start_early: got %b expected 0", tx_start); else pass_cnt++;
      wait_clk(1);
      chk_cnt++; if ({tx_start, busy} !== 2'b11) $display("FAIL basic_start: got %b expected 11", {tx_start, busy}); else pass_cnt++;
      done = 1'b1;          // arrives in START, must be ignored
      wait_clk(1);
      done = 1'b0;
      chk_cnt++; if ({ack, tx_start, busy} !== 6'b000001) $display("FAIL basic_done_in_start: got %b expected 000001", {ack, tx_start, busy}); else pass_cnt++;
      wait_clk(2);
      done = 1'b1;
      wait_clk(1);
      done = 1'b0; req = '0;
      chk_cnt++; if ({ack, grant, busy} !== 9'b0001_0000_0) $display("FAIL basic_ack: got %b expected 000100000", {ack, grant, busy}); else pass_cnt++;
      wait_clk(1);
      chk_cnt++; if (ack !== 4'b0000) $display("FAIL basic_ack_width: got %b expected 0000", ack); else pass_cnt++;
      wait_clk(3);
   endtask

   task automatic test_priority();
      logic [3:0] exp_g [3];
      int         exp_n [3];
      int         n;
      exp_g[0] = 4'b0010; exp_g[1] = 4'b0100; exp_g[2] = 4'b1000;
      exp_n[0] = 4;       exp_n[1] = 3;       exp_n[2] = 3;
      ids = {11'h400, 11'h0FF, 11'h0FF, 11'h000};
      req = 4'b1110;
      for (int i = 0; i < 3; i++) begin
         wait_start(n);
         chk_cnt++; if (n !== exp_n[i]) $display("FAIL prio_latency%0d: got %0d expected %0d", i, n, exp_n[i]); else pass_cnt++;
         chk_cnt++; if (grant !== exp_g[i]) $display("FAIL prio_grant%0d: got %b expected %b", i, grant, exp_g[i]); else pass_cnt++;
         wait_clk(1);
         done = 1'b1;
         wait_clk(1);
         done = 1'b0;
         req = req & ~exp_g[i];
         chk_cnt++; if (ack !== exp_g[i]) $display("FAIL prio_ack%0d: got %b expected %b", i, ack, exp_g[i]); else pass_cnt++;
      end
      wait_clk(3);
   endtask

   task automatic test_bus_idle();
      int n;
      logic seen;
      seen = 1'b0;
      rx = 1'b0;
      wait_clk(1);
      rx = 1'b1;
      wait_clk(2);
      ids = {11'h0, 11'h0, 11'h0, 11'h123};
      req = 4'b0001;
      for (int i = 0; i < 105; i++) begin
         wait_clk(1);
         if (tx_start) seen = 1'b1;
      end
      chk_cnt++; if (seen !== 1'b0) $display("FAIL idle_early_start: got %b expected 0", seen); else pass_cnt++;
      rx = 1'b0;
      n = 0;
      forever begin
         wait_clk(1);
         n++;
         if (n == 1) rx = 1'b1;
         if (tx_start) break;
         if (n >= 300) begin n = -1; break; end
      end
      chk_cnt++; if (n !== 115) $display("FAIL idle_restart_latency: got %0d expected 115", n); else pass_cnt++;
      wait_clk(1);
      done = 1'b1;
      wait_clk(1);
      done = 1'b0; req = '0;
      chk_cnt++; if (ack !== 4'b0001) $display("FAIL idle_ack: got %b expected 0001", ack); else pass_cnt++;
      wait_clk(3);
   endtask

   task automatic test_retry();
      int n;
      logic seen;
      ids = {11'h0, 11'h0, 11'h0, 11'h050};
      req = 4'b0001;
      for (int a = 0; a < 3; a++) begin
         wait_start(n);
         chk_cnt++; if (n !== ((a == 0) ? 4 : 2)) $display("FAIL retry_start%0d: got %0d expected %0d", a, n, (a == 0) ? 4 : 2); else pass_cnt++;
         wait_clk(1);
         lost = 1'b1;
         wait_clk(1);
         lost = 1'b0;
         if (a < 2) begin
            chk_cnt++; if ({abort_p, grant, busy} !== 9'b0000_0001_0) $display("FAIL retry_lost%0d: got %b expected 000000010", a, {abort_p, grant, busy}); else pass_cnt++;
         end
      end
      chk_cnt++; if ({abort_p, grant} !== 8'b0001_0000) $display("FAIL retry_abort: got %b expected 00010000", {abort_p, grant}); else pass_cnt++;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         wait_clk(1);
         if (tx_start || busy) seen = 1'b1;
      end
      chk_cnt++; if (seen !== 1'b0) $display("FAIL retry_blocked: got %b expected 0", seen); else pass_cnt++;
      req = 4'b0000;
      wait_clk(1);
      req = 4'b0001;
      wait_start(n);
      chk_cnt++; if (n !== 4 || grant !== 4'b0001) $display("FAIL retry_unblock: got n=%0d grant=%b expected n=4 grant=0001", n, grant); else pass_cnt++;
      wait_clk(1);
      done = 1'b1;
      wait_clk(1);
      done = 1'b0; req = '0;
      chk_cnt++; if (ack !== 4'b0001) $display("FAIL retry_ack: got %b expected 0001", ack); else pass_cnt++;
      wait_clk(3);
   endtask

   task automatic test_preempt();
      int n;
      ids = {11'h0, 11'h200, 11'h0, 11'h010};
      req = 4'b0100;
      wait_start(n);
      chk_cnt++; if (grant !== 4'b0100) $display("FAIL preempt_first: got %b expected 0100", grant); else pass_cnt++;
      wait_clk(1);
      req = 4'b0101;
      wait_clk(3);
      chk_cnt++; if ({grant, tx_id, busy} !== {4'b0100, 11'h200, 1'b1}) $display("FAIL preempt_frozen: got %b/%h/%b expected 0100/200/1", grant, tx_id, busy); else pass_cnt++;
      lost = 1'b1;
      wait_clk(1);
      lost = 1'b0;
      wait_start(n);
      chk_cnt++; if (n !== 2 || grant !== 4'b0001 || tx_id !== 11'h010) $display("FAIL preempt_regrant: got n=%0d %b/%h expected n=2 0001/010", n, grant, tx_id); else pass_cnt++;
      wait_clk(1);
      done = 1'b1; lost = 1'b1;
      wait_clk(1);
      done = 1'b0; lost = 1'b0;
      req = 4'b0100;
      chk_cnt++; if ({ack, abort_p, busy} !== 9'b0001_0000_0) $display("FAIL preempt_done_wins: got %b expected 000100000", {ack, abort_p, busy}); else pass_cnt++;
      wait_start(n);
      chk_cnt++; if (n !== 3 || grant !== 4'b0100) $display("FAIL preempt_resume: got n=%0d grant=%b expected n=3 grant=0100", n, grant); else pass_cnt++;
      wait_clk(1);
      done = 1'b1;
      wait_clk(1);
      done = 1'b0; req = '0;
      chk_cnt++; if (ack !== 4'b0100) $display("FAIL preempt_ack2: got %b expected 0100", ack); else pass_cnt++;
      wait_clk(3);
   endtask

   task automatic test_timeout();
      int n;
      ids = {11'h7FF, 11'h0, 11'h0, 11'h0};
      req = 4'b1000;
      wait_start(n);
      chk_cnt++; if (n !== 4) $display("FAIL timeout_start: got %0d expected 4", n); else pass_cnt++;
`ifdef CAN_SCHED_TIMEOUT_EN
      wait_clk(40);
      chk_cnt++; if (busy !== 1'b1) $display("FAIL timeout_before: got %b expected 1", busy); else pass_cnt++;
      wait_clk(1);
      chk_cnt++; if (busy !== 1'b0) $display("FAIL timeout_fire: got %b expected 0", busy); else pass_cnt++;
      wait_start(n);
      chk_cnt++; if (n !== 2) $display("FAIL timeout_restart: got %0d expected 2", n); else pass_cnt++;
      wait_clk(1);
`else
      wait_clk(60);
      chk_cnt++; if ({busy, grant, tx_id} !== {1'b1, 4'b1000, 11'h7FF}) $display("FAIL no_timeout_hold: got %b/%b/%h expected 1/1000/7ff", busy, grant, tx_id); else pass_cnt++;
`endif
      done = 1'b1;
      wait_clk(1);
      done = 1'b0; req = '0;
      chk_cnt++; if (ack !== 4'b1000) $display("FAIL timeout_ack: got %b expected 1000", ack); else pass_cnt++;
      wait_clk(3);
   endtask

   task automatic test_reset_mid();
      int n;
      ids = {11'h0, 11'h0, 11'h155, 11'h0};
      req = 4'b0010;
      wait_start(n);
      wait_clk(1);
      #2 rst_n = 1'b0;
      #1;
      chk_cnt++; if ({grant, busy, tx_id} !== 16'd0) $display("FAIL midreset_outs: got %h expected 0", {grant, busy, tx_id}); else pass_cnt++;
      req = '0;
      wait_clk(2);
      rst_n = 1'b1;
      wait_clk(5);
      chk_cnt++; if ({ack, abort_p, busy} !== 9'd0) $display("FAIL midreset_no_pulse: got %b expected 0", {ack, abort_p, busy}); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_priority();
      test_bus_idle();
      test_retry();
      test_preempt();
      test_timeout();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
